// File: rtl/serial_comparator.sv
// MSB-first digit-serial magnitude comparator (signed or unsigned), exits early at the first differing digit.
// Latency k+2 cycles from the start edge (k = deciding digit); start is ignored unless idle, with no queueing.
module serial_comparator #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             EQ,
    output logic             GT,
    output logic             LT,
    output logic             GE,
    output logic             LE
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [KW-1:0] LAST_K = KW'(NDIG - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [KW-1:0]    r_k;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_busy;
    logic             r_done;
    logic             r_eq;
    logic             r_gt;
    logic             r_lt;
    logic             r_ge;
    logic             r_le;

    // Operands are shifted left each step, so the digit under test is always the top one.
    logic [DIGIT-1:0] w_a_dig;
    logic [DIGIT-1:0] w_b_dig;
    logic             w_dig_gt;
    logic             w_dig_lt;

    assign w_a_dig  = r_a[WIDTH-1 -: DIGIT];
    assign w_b_dig  = r_b[WIDTH-1 -: DIGIT];
    assign w_dig_gt = (w_a_dig > w_b_dig);
    assign w_dig_lt = (w_a_dig < w_b_dig);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_eq    <= 1'b0;
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
            r_ge    <= 1'b0;
            r_le    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        // Sign-bit flip maps two's complement onto offset binary.
                        r_a     <= {A[WIDTH-1] ^ sgn, A[WIDTH-2:0]};
                        r_b     <= {B[WIDTH-1] ^ sgn, B[WIDTH-2:0]};
                        r_k     <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_dig_gt || w_dig_lt) begin
                        r_eq    <= 1'b0;
                        r_gt    <= w_dig_gt;
                        r_lt    <= w_dig_lt;
                        r_ge    <= w_dig_gt;
                        r_le    <= w_dig_lt;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_k == LAST_K) begin
                        r_eq    <= 1'b1;
                        r_gt    <= 1'b0;
                        r_lt    <= 1'b0;
                        r_ge    <= 1'b1;
                        r_le    <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_k <= r_k + KW'(1);
                        r_a <= r_a << DIGIT;
                        r_b <= r_b << DIGIT;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign EQ   = r_eq;
    assign GT   = r_gt;
    assign LT   = r_lt;
    assign GE   = r_ge;
    assign LE   = r_le;

endmodule

// File: tb/tb_serial_comparator.sv
// Bench for serial_comparator (WIDTH=8, DIGIT=2): directed scenarios plus a random scoreboard sweep.
module tb_serial_comparator;
    localparam int W    = 8;
    localparam int D    = 2;
    localparam int NDIG = W / D;

    typedef struct {
        logic [4:0] flags;  // {EQ, GT, LT, GE, LE}
        int         lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sgn;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic         EQ, GT, LT, GE, LE;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   t_start  = 0;
    exp_t sb[$];

    serial_comparator #(.WIDTH(W), .DIGIT(D)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .sgn  (sgn),
        .A    (A),
        .B    (B),
        .busy (busy),
        .done (done),
        .EQ   (EQ),
        .GT   (GT),
        .LT   (LT),
        .GE   (GE),
        .LE   (LE)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t         e;
        logic         gt, lt, eq;
        logic [W-1:0] x;
        bit           found;
        if (s) begin
            gt = $signed(a) > $signed(b);
            lt = $signed(a) < $signed(b);
        end else begin
            gt = a > b;
            lt = a < b;
        end
        eq = (a == b);
        e.flags = {eq, gt, lt, gt | eq, lt | eq};
        x = a ^ b;
        found = 0;
        e.lat = NDIG - 1 + 2;
        for (int d = 0; d < NDIG; d++) begin
            if (!found && (((x >> (W - D * (d + 1))) & W'((1 << D) - 1)) != '0)) begin
                found = 1;
                e.lat = d + 2;
            end
        end
        return e;
    endfunction

    // Drives one start pulse; optionally records the expected outcome.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input bit push);
        if (push) sb.push_back(model(a, b, s));
        @(negedge clk);
        A = a; B = b; sgn = s; start = 1'b1;
        @(posedge clk); #1;
        t_start = cyc;
        start = 1'b0;
        A = W'($urandom); B = W'($urandom); sgn = 1'($urandom);
    endtask

    // Waits (bounded) for done, then one more edge so the DUT is back in IDLE.
    task automatic wait_done(output bit ok, output int lat);
        ok = 0;
        lat = 0;
        for (int i = 0; i < 4 * NDIG + 8; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                ok = 1;
                lat = cyc - t_start + 1;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        int ndone;
        rst = 1'b1; start = 1'b1; sgn = 1'b0; A = 8'h12; B = 8'h34;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, EQ, GT, LT, GE, LE} !== 7'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=0000000", {busy, done, EQ, GT, LT, GE, LE});
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        ndone = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            failures++;
            $display("FAIL reset_no_done got=%0d want=0", ndone);
        end
    endtask

    task automatic test_sign();
        bit   ok;
        int   lat;
        exp_t e;
        for (int m = 1; m >= 0; m--) begin
            issue(8'h80, 8'h7F, 1'(m), 1);
            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("FAIL sign_busy sgn=%0d got=%b want=1", m, busy);
            end
            wait_done(ok, lat);
            e = sb.pop_front();
            checks++;
            if (!ok || {EQ, GT, LT, GE, LE} !== e.flags) begin
                failures++;
                $display("FAIL sign_flags sgn=%0d ok=%0d got=%b want=%b", m, ok, {EQ, GT, LT, GE, LE}, e.flags);
            end
            checks++;
            if (lat != 2) begin
                failures++;
                $display("FAIL sign_latency sgn=%0d got=%0d want=2", m, lat);
            end
        end
    endtask

    task automatic test_equal();
        bit   ok;
        int   lat;
        exp_t e;
        issue(8'hA5, 8'hA5, 1'b0, 1);
        wait_done(ok, lat);
        e = sb.pop_front();
        checks++;
        if (!ok || {EQ, GT, LT, GE, LE} !== 5'b10011) begin
            failures++;
            $display("FAIL equal_flags ok=%0d got=%b want=10011", ok, {EQ, GT, LT, GE, LE});
        end
        checks++;
        if (lat != e.lat || lat != NDIG + 1) begin
            failures++;
            $display("FAIL equal_latency got=%0d want=%0d", lat, NDIG + 1);
        end
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL equal_done_pulse got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_late_diff();
        bit   ok;
        int   lat, ndone;
        exp_t e;
        issue(8'h10, 8'h11, 1'b0, 1);
        @(negedge clk);
        A = 8'h00; B = 8'h00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(ok, lat);
        e = sb.pop_front();
        checks++;
        if (!ok || {EQ, GT, LT, GE, LE} !== 5'b00101) begin
            failures++;
            $display("FAIL late_flags ok=%0d got=%b want=00101", ok, {EQ, GT, LT, GE, LE});
        end
        checks++;
        if (lat != e.lat || lat != 5) begin
            failures++;
            $display("FAIL late_latency got=%0d want=5", lat);
        end
        ndone = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0 || {EQ, GT, LT, GE, LE} !== 5'b00101) begin
            failures++;
            $display("FAIL late_ignored_start got extra_done=%0d flags=%b want 0 00101", ndone, {EQ, GT, LT, GE, LE});
        end
    endtask

    task automatic test_reset_mid();
        bit   ok;
        int   lat, ndone;
        exp_t e;
        issue(8'h01, 8'h00, 1'b0, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_busy got=%b want=0", busy);
        end
        ndone = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0 || {EQ, GT, LT, GE, LE} !== 5'b0) begin
            failures++;
            $display("FAIL rstmid_discard got done=%0d flags=%b want 0 00000", ndone, {EQ, GT, LT, GE, LE});
        end
        issue(8'h01, 8'h00, 1'b0, 1);
        wait_done(ok, lat);
        e = sb.pop_front();
        checks++;
        if (!ok || {EQ, GT, LT, GE, LE} !== e.flags || lat != e.lat) begin
            failures++;
            $display("FAIL rstmid_next got=%b lat=%0d want=%b lat=%0d", {EQ, GT, LT, GE, LE}, lat, e.flags, e.lat);
        end
    endtask

    task automatic test_back_to_back();
        int t[3];
        int n;
        n = 0;
        @(negedge clk);
        A = 8'h40; B = 8'h00; sgn = 1'b0; start = 1'b1;
        for (int i = 0; i < 30 && n < 3; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                t[n] = cyc;
                n++;
            end
        end
        start = 1'b0;
        checks++;
        if (n != 3) begin
            failures++;
            $display("FAIL b2b_count got=%0d want=3", n);
        end else begin
            checks++;
            if (t[1] - t[0] != 3 || t[2] - t[1] != 3) begin
                failures++;
                $display("FAIL b2b_period got=%0d,%0d want=3,3", t[1] - t[0], t[2] - t[1]);
            end
        end
        checks++;
        if ({EQ, GT, LT, GE, LE} !== 5'b01010) begin
            failures++;
            $display("FAIL b2b_flags got=%b want=01010", {EQ, GT, LT, GE, LE});
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        bit           ok;
        int           lat;
        exp_t         e;
        logic [W-1:0] a, b;
        logic         s;
        for (int n = 0; n < 1500; n++) begin
            a = W'($urandom);
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = a ^ W'(1 << $urandom_range(0, W - 1));
                default: b = W'($urandom);
            endcase
            s = 1'($urandom);
            issue(a, b, s, 1);
            wait_done(ok, lat);
            e = sb.pop_front();
            checks++;
            if (!ok || {EQ, GT, LT, GE, LE} !== e.flags) begin
                failures++;
                $display("FAIL rand_flags a=%h b=%h s=%0d got=%b want=%b", a, b, s, {EQ, GT, LT, GE, LE}, e.flags);
            end
            checks++;
            if (lat != e.lat) begin
                failures++;
                $display("FAIL rand_latency a=%h b=%h got=%0d want=%0d", a, b, lat, e.lat);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sgn = 1'b0; A = '0; B = '0;
        test_reset();
        test_sign();
        test_equal();
        test_late_diff();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
